// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg: shared state encoding, requester count and hold counter width
package rr_arbiter_4_pkg;
  localparam int N_REQ = 4;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if: request/done lines in, one-hot grants plus busy/timeout out; master = requesters, slave = arbiter
interface rr_arbiter_4_if;
  logic r0, r1, r2, r3;
  logic done;
  logic g0, g1, g2, g3;
  logic busy;
  logic timeout;
  modport master (output r0, r1, r2, r3, done, input g0, g1, g2, g3, busy, timeout);
  modport slave  (input r0, r1, r2, r3, done, output g0, g1, g2, g3, busy, timeout);
endinterface

// File: rtl/rr_arbiter_4_pick4.sv
// rr_pick4: combinational round-robin search; req_i/ptr_i in, first requesting index at or after ptr_i on idx_o, found_o if any
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [1:0]       idx_o,
  output logic             found_o
);
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_i[ptr_i + 2'(i)]) begin
        idx_o = ptr_i + 2'(i);
        found_o = 1'b1;
      end
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with bounded hold; clk, async rst, bus (slave: r0..r3, done in; g0..g3, busy, timeout out)
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_4_if.slave bus
);
  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] g_q, g_d, req;
  logic             busy_q, busy_d, timeout_q, timeout_d, pick_found, rel, tmo;
  assign req = {bus.r3, bus.r2, bus.r1, bus.r0};
  assign rel = bus.done || !req[idx_q];
  assign tmo = cnt_q == CNT_W'(MAX_HOLD - 1);
  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    g_d = '0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (pick_found) begin
        state_d = GRANT;
        idx_d = pick_idx;
        ptr_d = pick_idx + 2'd1;
        cnt_d = '0;
        g_d = 4'b0001 << pick_idx;
      end
      GRANT: begin
        state_d = (rel || tmo) ? RELEASE : GRANT;
        timeout_d = !rel && tmo;
        g_d = (rel || tmo) ? '0 : 4'b0001 << idx_q;
        cnt_d = (rel || tmo) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = |g_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      g_q <= '0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      g_q <= g_d;
      busy_q <= busy_d;
      timeout_q <= timeout_d;
    end
  assign {bus.g3, bus.g2, bus.g1, bus.g0} = g_q;
  assign bus.busy = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed and random stimulus against a transaction-level arbiter model
module tb_rr_arbiter_4;
  localparam int MAX_HOLD = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  rr_arbiter_4_if bus ();
  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int m_owner = -1;
  int m_held = 0;
  int m_gap = 0;
  int m_next = 0;
  bit m_tmo = 0;
  logic [3:0] g;
  assign g = {bus.g3, bus.g2, bus.g1, bus.g0};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_held = 0;
    m_gap = 0;
    m_next = 0;
    m_tmo = 0;
  endtask
  // One grant lives for m_held cycles; after it ends two empty cycles pass before the next arbitration.
  task automatic model_step(input logic [3:0] r, input logic d);
    m_tmo = 0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_owner = -1;
        m_gap = 1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1;
        m_gap = 1;
        m_tmo = 1;
      end else m_held++;
    end else if (m_gap > 0) m_gap--;
    else
      for (int i = 0; i < 4; i++) begin
        automatic int k = (m_next + i) % 4;
        if (r[k]) begin
          m_owner = k;
          m_held = 1;
          m_next = (k + 1) % 4;
          break;
        end
      end
  endtask
  task automatic compare();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    check("grants", 32'(g), 32'(eg));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    check("timeout", 32'(bus.timeout), 32'(m_tmo));
    check("onehot", 32'($countones(g) <= 1), 32'd1);
    check("busy_or", 32'(bus.busy), 32'(|g));
  endtask
  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    {bus.r3, bus.r2, bus.r1, bus.r0} = r;
    bus.done = d;
    @(posedge clk);
    model_step(r, d);
    #1 compare();
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    {bus.r3, bus.r2, bus.r1, bus.r0} = 4'h0;
    bus.done = 1'b0;
    #1;
    check("rst_g", 32'(g), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int cnt;
    int idx;
    bit seen;
    logic [3:0] r;
    logic d;
    {bus.r3, bus.r2, bus.r1, bus.r0} = 4'h0;
    bus.done = 1'b0;
    do_reset();
    // r2 alone, early release by done
    repeat (3) step(4'b0100, 1'b0);
    check("r2_granted", 32'(bus.g2), 32'd1);
    step(4'b0100, 1'b1);
    check("r2_done_g2", 32'(bus.g2), 32'd0);
    check("r2_done_tmo", 32'(bus.timeout), 32'd0);
    step(4'b0100, 1'b0);
    check("r2_idle_g", 32'(g), 32'd0);
    // all requesting: rotation 0,1,2,3,0
    do_reset();
    for (int n = 0; n < 5; n++) begin
      seen = 0;
      for (int t = 0; t < 6 && !seen; t++) begin
        step(4'b1111, 1'b0);
        seen = bus.busy;
      end
      check("rot_seen", 32'(seen), 32'd1);
      idx = 0;
      for (int b = 0; b < 4; b++) if (g[b]) idx = b;
      check("rot_order", 32'(idx), 32'(n % 4));
      step(4'b1111, 1'b1);
    end
    // r1 held, no done: hold limit, timeout pulse, regrant
    cnt = 0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step(4'b0010, 1'b0);
      seen = bus.timeout;
      if (bus.g1) cnt++;
    end
    check("hold_timeout_seen", 32'(seen), 32'd1);
    check("hold_len", 32'(cnt), 32'(MAX_HOLD));
    step(4'b0010, 1'b0);
    check("hold_gap_tmo", 32'(bus.timeout), 32'd0);
    check("hold_gap_g", 32'(g), 32'd0);
    step(4'b0010, 1'b0);
    check("hold_regrant", 32'(bus.g1), 32'd1);
    // done coinciding with the hold limit
    repeat (MAX_HOLD - 1) step(4'b0010, 1'b0);
    check("coinc_still", 32'(bus.g1), 32'd1);
    step(4'b0010, 1'b1);
    check("coinc_g1", 32'(bus.g1), 32'd0);
    check("coinc_tmo", 32'(bus.timeout), 32'd0);
    // reset during g3, then r3+r0 picks g0
    do_reset();
    repeat (2) step(4'b1000, 1'b0);
    check("pre_rst_g3", 32'(bus.g3), 32'd1);
    do_reset();
    step(4'b1001, 1'b0);
    check("post_rst_g0", 32'(bus.g0), 32'd1);
    // random traffic: slowly changing request sets, sparse done
    r = 4'h0;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 9) == 0);
      step(r, d);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
